// File: rtl/hazard_pkg.sv
// Shared types and constants for destination-register tracking across EX/MEM/WB.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [REG_ADDR_W_DEF-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic                      rf_en;
        logic                      load;
    } stage_meta_t;

    localparam stage_meta_t BUBBLE = '{rd: '0, rf_en: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_dest_tracker_dest_decode.sv
// Combinational instruction -> destination metadata decode (rd, write enable, load).
module dest_decode
    import hazard_pkg::*;
(
    input  logic [31:0] instr,
    output stage_meta_t meta
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Opcode-driven decode; a zero destination collapses to a bubble so r0 is never forwarded.
    always_comb begin
        stage_meta_t raw;
        raw = BUBBLE;
        if (op == OP_RTYPE) begin
            if (!(funct == FN_JR || (funct >= FN_MULT && funct <= FN_DIVU))) begin
                raw.rd    = instr[15:11];
                raw.rf_en = 1'b1;
            end
        end else if (op >= OP_ADDI && op <= OP_LUI) begin
            raw.rd    = instr[20:16];
            raw.rf_en = 1'b1;
        end else if (op == OP_LB || op == OP_LH || op == OP_LW ||
                     op == OP_LBU || op == OP_LHU) begin
            raw.rd    = instr[20:16];
            raw.rf_en = 1'b1;
            raw.load  = 1'b1;
        end else if (op == OP_JAL) begin
            raw.rd    = REG_RA;
            raw.rf_en = 1'b1;
        end
        meta = (raw.rd == '0) ? BUBBLE : raw;
    end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Destination-register metadata pipeline (EX/MEM/WB) feeding the hazard/forwarding unit.
// Optional stall/retire statistics are built when STALL_STATS_EN is defined.
module hazard_dest_tracker
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           id_instr,
    input  logic                  id_valid,
    input  logic                  bubble_ex,
    input  logic                  flush_id,
    output logic [REG_ADDR_W-1:0] id_rs,
    output logic [REG_ADDR_W-1:0] id_rt,
    output logic [REG_ADDR_W-1:0] rd_ex,
    output logic [REG_ADDR_W-1:0] rd_mem,
    output logic [REG_ADDR_W-1:0] rd_wb,
    output logic                  EX_RF_Enable,
    output logic                  MEM_RF_Enable,
    output logic                  WB_RF_Enable,
    output logic                  EX_load_instr,
    output logic [STAT_W-1:0]     bubble_count,
    output logic [STAT_W-1:0]     retire_count
);

    stage_meta_t id_meta;
    stage_meta_t ex_q;
    stage_meta_t mem_q;
    stage_meta_t wb_q;
    logic        insert_bubble;

    dest_decode u_dest_decode (
        .instr (id_instr),
        .meta  (id_meta)
    );

    assign insert_bubble = bubble_ex | flush_id | ~id_valid;

    // Stage shift: MEM and WB always advance; EX takes the ID decode or a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= insert_bubble ? BUBBLE : id_meta;
        end
    end

    assign id_rs         = REG_ADDR_W'(id_instr[25:21]);
    assign id_rt         = REG_ADDR_W'(id_instr[20:16]);
    assign rd_ex         = REG_ADDR_W'(ex_q.rd);
    assign rd_mem        = REG_ADDR_W'(mem_q.rd);
    assign rd_wb         = REG_ADDR_W'(wb_q.rd);
    assign EX_RF_Enable  = ex_q.rf_en;
    assign MEM_RF_Enable = mem_q.rf_en;
    assign WB_RF_Enable  = wb_q.rf_en;
    assign EX_load_instr = ex_q.load & ex_q.rf_en;

`ifdef STALL_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] bubble_cnt_q;
    logic [STAT_W-1:0] retire_cnt_q;

    // Saturating counters: bubble requests and writing instructions leaving WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (bubble_ex && bubble_cnt_q != STAT_MAX)
                bubble_cnt_q <= bubble_cnt_q + STAT_W'(1);
            if (wb_q.rf_en && retire_cnt_q != STAT_MAX)
                retire_cnt_q <= retire_cnt_q + STAT_W'(1);
        end
    end

    assign bubble_count = bubble_cnt_q;
    assign retire_count = retire_cnt_q;
`else
    assign bubble_count = '0;
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Scoreboard bench for hazard_dest_tracker: driver pushes hand-computed expectations,
// monitor pops and compares after each rising edge.
module tb_hazard_dest_tracker;

`ifdef STALL_STATS_EN
    localparam int STAT_W = 4;
    localparam bit STATS  = 1'b1;
`else
    localparam int STAT_W = 16;
    localparam bit STATS  = 1'b0;
`endif
    localparam int SMAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       id_instr;
    logic              id_valid, bubble_ex, flush_id;
    logic [4:0]        id_rs, id_rt, rd_ex, rd_mem, rd_wb;
    logic              EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable, EX_load_instr;
    logic [STAT_W-1:0] bubble_count, retire_count;

    hazard_dest_tracker #(.REG_ADDR_W(5), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .bubble_ex     (bubble_ex),
        .flush_id      (flush_id),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .rd_ex         (rd_ex),
        .rd_mem        (rd_mem),
        .rd_wb         (rd_wb),
        .EX_RF_Enable  (EX_RF_Enable),
        .MEM_RF_Enable (MEM_RF_Enable),
        .WB_RF_Enable  (WB_RF_Enable),
        .EX_load_instr (EX_load_instr),
        .bubble_count  (bubble_count),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int rs, rt;
        int rd_ex, en_ex, ld_ex;
        int rd_mem, en_mem;
        int rd_wb, en_wb;
        int bcnt, rcnt;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    int m_rd_ex = 0, m_en_ex = 0, m_ld_ex = 0;
    int m_rd_mem = 0, m_en_mem = 0;
    int m_rd_wb = 0, m_en_wb = 0;
    int m_bcnt = 0, m_rcnt = 0;

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_rd_ex = 0; m_en_ex = 0; m_ld_ex = 0;
        m_rd_mem = 0; m_en_mem = 0;
        m_rd_wb = 0; m_en_wb = 0;
        m_bcnt = 0; m_rcnt = 0;
    endtask

    // One clock of stimulus; erd/een/eld are the hand-decoded EX record expected after the edge.
    task automatic step(string tag, logic [31:0] instr, bit v, bit b, bit f,
                        int erd, int een, int eld);
        exp_t e;
        @(negedge clk);
        id_instr  = instr;
        id_valid  = v;
        bubble_ex = b;
        flush_id  = f;
        if (m_en_wb != 0 && m_rcnt < SMAX) m_rcnt++;
        if (b && m_bcnt < SMAX) m_bcnt++;
        m_rd_wb  = m_rd_mem; m_en_wb  = m_en_mem;
        m_rd_mem = m_rd_ex;  m_en_mem = m_en_ex;
        m_rd_ex  = erd;      m_en_ex  = een;   m_ld_ex = eld;
        e.tag    = tag;
        e.rs     = int'(instr[25:21]);
        e.rt     = int'(instr[20:16]);
        e.rd_ex  = m_rd_ex;  e.en_ex  = m_en_ex; e.ld_ex = m_ld_ex;
        e.rd_mem = m_rd_mem; e.en_mem = m_en_mem;
        e.rd_wb  = m_rd_wb;  e.en_wb  = m_en_wb;
        e.bcnt   = STATS ? m_bcnt : 0;
        e.rcnt   = STATS ? m_rcnt : 0;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(string tag);
        cmp({tag, " rd_ex"}, int'(rd_ex), 0);
        cmp({tag, " rd_mem"}, int'(rd_mem), 0);
        cmp({tag, " rd_wb"}, int'(rd_wb), 0);
        cmp({tag, " EX_RF_Enable"}, int'(EX_RF_Enable), 0);
        cmp({tag, " MEM_RF_Enable"}, int'(MEM_RF_Enable), 0);
        cmp({tag, " WB_RF_Enable"}, int'(WB_RF_Enable), 0);
        cmp({tag, " EX_load_instr"}, int'(EX_load_instr), 0);
        cmp({tag, " bubble_count"}, int'(bubble_count), 0);
        cmp({tag, " retire_count"}, int'(retire_count), 0);
    endtask

    // Monitor: after every rising edge, pop one expectation if the driver issued one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({e.tag, " id_rs"}, int'(id_rs), e.rs);
                cmp({e.tag, " id_rt"}, int'(id_rt), e.rt);
                cmp({e.tag, " rd_ex"}, int'(rd_ex), e.rd_ex);
                cmp({e.tag, " EX_RF_Enable"}, int'(EX_RF_Enable), e.en_ex);
                cmp({e.tag, " EX_load_instr"}, int'(EX_load_instr), e.ld_ex);
                cmp({e.tag, " rd_mem"}, int'(rd_mem), e.rd_mem);
                cmp({e.tag, " MEM_RF_Enable"}, int'(MEM_RF_Enable), e.en_mem);
                cmp({e.tag, " rd_wb"}, int'(rd_wb), e.rd_wb);
                cmp({e.tag, " WB_RF_Enable"}, int'(WB_RF_Enable), e.en_wb);
                cmp({e.tag, " bubble_count"}, int'(bubble_count), e.bcnt);
                cmp({e.tag, " retire_count"}, int'(retire_count), e.rcnt);
            end
        end
    end

    // Driver: directed instruction sequence.
    initial begin
        reset = 1'b1; id_instr = 32'h0; id_valid = 1'b0; bubble_ex = 1'b0; flush_id = 1'b0;
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // add $3,$1,$2 for one cycle, then follow it down the pipe
        step("add",      32'h00221820, 1, 0, 0, 3, 1, 0);
        step("add+1",    32'h00000000, 0, 0, 0, 0, 0, 0);
        step("add+2",    32'h00000000, 0, 0, 0, 0, 0, 0);
        step("add+3",    32'h00000000, 0, 0, 0, 0, 0, 0);

        // load-use: lw, one bubble, then the same lw re-presented
        step("lw",       32'h8C850000, 1, 0, 0, 5, 1, 1);
        step("lw_stall", 32'h8C850000, 1, 1, 0, 0, 0, 0);
        step("lw_again", 32'h8C850000, 1, 0, 0, 5, 1, 1);

        // non-writing opcodes and special cases
        step("sw",       32'hAC850000, 1, 0, 0, 0, 0, 0);
        step("beq",      32'h10220003, 1, 0, 0, 0, 0, 0);
        step("addi_r0",  32'h20000005, 1, 0, 0, 0, 0, 0);
        step("jr",       32'h03E00008, 1, 0, 0, 0, 0, 0);
        step("jal",      32'h0C000010, 1, 0, 0, 31, 1, 0);
        step("mult",     32'h00220018, 1, 0, 0, 0, 0, 0);
        step("add_r0",   32'h00220020, 1, 0, 0, 0, 0, 0);
        step("lui",      32'h3C070001, 1, 0, 0, 7, 1, 0);
        step("lb",       32'h80A60000, 1, 0, 0, 6, 1, 1);

        // flush alone, flush with bubble, then the ID instruction decodes
        step("flush",    32'h00221820, 1, 0, 1, 0, 0, 0);
        step("flush_bub",32'h00221820, 1, 1, 1, 0, 0, 0);
        step("post_fb",  32'h00221820, 1, 0, 0, 3, 1, 0);

        // fill all stages, then async reset mid-cycle
        step("fill_lw",  32'h8C850000, 1, 0, 0, 5, 1, 1);
        step("fill_jal", 32'h0C000010, 1, 0, 0, 31, 1, 0);
        @(posedge clk);
        #3;
        reset = 1'b1; id_valid = 1'b0; bubble_ex = 1'b0; flush_id = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();

        // statistics: three writers retire, then 20 bubble cycles
        step("st_add0",  32'h00221820, 1, 0, 0, 3, 1, 0);
        step("st_add1",  32'h00221820, 1, 0, 0, 3, 1, 0);
        step("st_add2",  32'h00221820, 1, 0, 0, 3, 1, 0);
        for (int i = 0; i < 20; i++)
            step("st_bub", 32'h00221820, 1, 1, 0, 0, 0, 0);
        step("st_end",   32'h00000000, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        cmp("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_dest_tracker.md
# hazard_dest_tracker

Tracks destination-register metadata for every instruction leaving ID as it moves through EX, MEM and WB. It produces the stage-tagged destination, write-enable and load flags consumed by the hazard/forwarding unit. It also consumes that unit's stall decision by inserting a bubble into EX. It sits alongside the ID/EX, EX/MEM and MEM/WB pipeline registers and is the single source of truth for the forwarding comparators.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- STAT_W, 16, statistics counter width (used only with STALL_STATS_EN)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; clears all state
- id_instr  in  32  instruction currently in ID
- id_valid  in  1  id_instr is a real instruction
- bubble_ex  in  1  hazard unit requests a NOP into EX this cycle (load-use stall)
- flush_id  in  1  squash the ID instruction (taken branch/jump)
- id_rs, id_rt  out  REG_ADDR_W each  instr[25:21], instr[20:16]; combinational
- rd_ex, rd_mem, rd_wb  out  REG_ADDR_W each  destination per stage
- EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable  out  1 each  stage will write the register file
- EX_load_instr  out  1  EX holds a load with a live destination
- bubble_count  out  STAT_W  saturating count of bubble_ex cycles
- retire_count  out  STAT_W  saturating count of writing instructions that left WB

## Operation
Destination decode, op = instr[31:26]:
- op 0x00: dest = instr[15:11], en = 1, except funct 0x08 (jr) and 0x18–0x1B (mult/div), which give en = 0
- op 0x08–0x0F (addi…lui): dest = rt, en = 1
- op 0x20, 0x21, 0x23, 0x24, 0x25 (loads): dest = rt, en = 1, load = 1
- op 0x03 (jal): dest = 31, en = 1
- all other opcodes (stores, branches, j): en = 0, dest = 0
- dest == 0 forces en = 0 and load = 0, so r0 is never forwarded
- Bubble record: rd = 0, en = 0, load = 0.

Each rising edge, not in reset:
- WB ← MEM, MEM ← EX, in all cases. Nothing downstream of EX ever stalls.
- EX ← bubble if bubble_ex | flush_id | ~id_valid, else EX ← decode(id_instr).
- bubble_ex together with flush_id: a single bubble.
- While stalled, the hazard unit holds IF/ID, so the same instruction is re-presented. It enters EX on the first cycle bubble_ex is low.

Outputs are registered, except id_rs and id_rt. EX_load_instr = ex.load & ex.en.

## Timing
- Reset (async assert): every registered output goes to 0 immediately. Counters go to 0. Release is synchronous to clk.
- Latency:
  - ID→EX outputs: 1 cycle
  - ID→MEM: 2 cycles
  - ID→WB: 3 cycles
  - WB record clears 1 cycle after its successor bubble arrives.
- Load-use: the cycle after a load enters EX, it moves to MEM. A single bubble_ex cycle therefore drops EX_load_instr to 0, which releases the stall.
- Reset mid-stall discards all in-flight records; no partial state survives.

## Configuration
STALL_STATS_EN:
- Defined:
  - bubble_count increments every cycle bubble_ex = 1.
  - retire_count increments every cycle WB_RF_Enable = 1.
  - Both saturate at 2^STAT_W−1 and never wrap.
- Undefined: counters are not built; both ports are tied to 0.
- The pipeline tracking behaviour is identical either way.

## Structure
- Shared package hazard_pkg:
  - opcode and funct localparams
  - REG_ADDR_W default
  - typedef stage_meta_t {rd, rf_en, load}
  - BUBBLE constant of stage_meta_t
- Sub-module dest_decode: combinational, instr → stage_meta_t. Reused by any future decode-stage logic.
- Top level holds three stage_meta_t registers plus the optional counters.

## Test plan
- add $3,$1,$2 (0x00221820), id_valid=1 for one cycle, then id_valid=0 → rd_ex=3/EX_RF_Enable=1 at cycle 1, rd_mem=3 at cycle 2, rd_wb=3 at cycle 3, WB_RF_Enable=0 at cycle 4.
- lw $5,0($4) (0x8C850000) → EX_load_instr=1. Then bubble_ex=1 for one cycle → EX_RF_Enable=0, EX_load_instr=0, rd_mem=5, MEM_RF_Enable=1.
- sw (0xAC850000), beq (0x10220003), addi $0,$0,5 (0x20000005), jr $31 (0x03E00008) → EX_RF_Enable=0 for each. jal (0x0C000010) → rd_ex=31, EX_RF_Enable=1.
- flush_id=1 with a valid add in ID → EX bubble. flush_id and bubble_ex together for one cycle → exactly one bubble; the next record decodes id_instr.
- Assert reset asynchronously mid-cycle with all stages full → every output reads 0 before the next clk edge.
- STALL_STATS_EN with STAT_W=4: 20 bubble_ex cycles → bubble_count=15 (saturated). 3 writing instructions retired → retire_count=3.
